// File: rtl/ov7670_axil_cfg_seq.sv
// AXI4-Lite master that loads the OV7670_VGA register bank after reset.
// Define OV7670_CFG_READBACK_EN to verify each word by reading it back.
module ov7670_axil_cfg_seq #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int AW = C_M_AXI_ADDR_WIDTH,
  localparam int DW = C_M_AXI_DATA_WIDTH,
  localparam int IW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               start,
  input  logic [NUM_REGS*DW-1:0] cfg_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [IW-1:0]      err_index,
  output logic [AW-1:0]      m_axi_awaddr,
  output logic [2:0]         m_axi_awprot,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [DW-1:0]      m_axi_wdata,
  output logic [DW/8-1:0]    m_axi_wstrb,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  input  logic [1:0]         m_axi_bresp,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  output logic [AW-1:0]      m_axi_araddr,
  output logic [2:0]         m_axi_arprot,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [DW-1:0]      m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
`ifdef OV7670_CFG_READBACK_EN
    RD_REQ,
    RD_RESP,
`endif
    FIN
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  state_t        state, st_n;
  logic [IW-1:0] idx, idx_n, iss_idx;
  logic          awv, awv_n;
  logic          wv, wv_n;
  logic [AW-1:0] addr_r, addr_n;
  logic [DW-1:0] data_r, data_n;
  logic          err_r, err_n;
  logic [IW-1:0] eidx_r, eidx_n;
  logic [7:0]    cnt, cnt_n;
  logic          issue, fail, adv;
  logic          aw_hs, w_hs, aw_ok, w_ok;
  logic          to, last;

  assign aw_hs = awv & m_axi_awready;
  assign w_hs  = wv & m_axi_wready;
  assign aw_ok = ~awv | m_axi_awready;
  assign w_ok  = ~wv | m_axi_wready;
  assign to    = (cnt == TO);
  assign last  = (idx == LAST);

  assign m_axi_awaddr  = addr_r;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awv;
  assign m_axi_wdata   = data_r;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wv;
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arprot  = 3'b000;
  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);
  assign error     = err_r;
  assign err_index = eidx_r;

`ifdef OV7670_CFG_READBACK_EN
  logic arv, arv_n;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arvalid = arv;
  assign m_axi_rready  = (state == RD_RESP);
`else
  logic unused_rd;
  assign unused_rd = ^{m_axi_arready, m_axi_rdata,
                       m_axi_rresp, m_axi_rvalid};
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
`endif

  // Next-state, handshake bookkeeping and fault capture
  always_comb begin
    st_n    = state;
    idx_n   = idx;
    awv_n   = awv;
    wv_n    = wv;
    addr_n  = addr_r;
    data_n  = data_r;
    err_n   = err_r;
    eidx_n  = eidx_r;
    issue   = 1'b0;
    iss_idx = '0;
    fail    = 1'b0;
    adv     = 1'b0;
`ifdef OV7670_CFG_READBACK_EN
    arv_n   = arv;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          issue  = 1'b1;
          err_n  = 1'b0;
          eidx_n = '0;
        end
      end
      WR_REQ: begin
        if (aw_ok && w_ok) begin
          awv_n = 1'b0;
          wv_n  = 1'b0;
          st_n  = WR_RESP;
        end else begin
          if (aw_hs) awv_n = 1'b0;
          if (w_hs)  wv_n  = 1'b0;
          if (to)    fail  = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            fail = 1'b1;
          end else begin
`ifdef OV7670_CFG_READBACK_EN
            st_n  = RD_REQ;
            arv_n = 1'b1;
`else
            adv = 1'b1;
`endif
          end
        end else if (to) begin
          fail = 1'b1;
        end
      end
`ifdef OV7670_CFG_READBACK_EN
      RD_REQ: begin
        if (m_axi_arready) begin
          arv_n = 1'b0;
          st_n  = RD_RESP;
        end else if (to) begin
          fail = 1'b1;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00 ||
              m_axi_rdata != data_r)
            fail = 1'b1;
          else
            adv = 1'b1;
        end else if (to) begin
          fail = 1'b1;
        end
      end
`endif
      FIN:     st_n = IDLE;
      default: st_n = IDLE;
    endcase
    if (adv) begin
      if (last) begin
        st_n = FIN;
      end else begin
        issue   = 1'b1;
        iss_idx = idx + 1'b1;
      end
    end
    if (issue) begin
      st_n   = WR_REQ;
      idx_n  = iss_idx;
      awv_n  = 1'b1;
      wv_n   = 1'b1;
      addr_n = BASE_ADDR + (AW'(iss_idx) << 2);
      data_n = cfg_data[int'(iss_idx)*DW +: DW];
    end
    if (fail) begin
      st_n   = FIN;
      awv_n  = 1'b0;
      wv_n   = 1'b0;
      err_n  = 1'b1;
      eidx_n = idx;
`ifdef OV7670_CFG_READBACK_EN
      arv_n  = 1'b0;
`endif
    end
    if (st_n != state || state == IDLE)
      cnt_n = '0;
    else
      cnt_n = cnt + 8'd1;
  end

  // State and registered outputs; reset drops every valid at once
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state  <= IDLE;
      idx    <= '0;
      awv    <= 1'b0;
      wv     <= 1'b0;
      addr_r <= '0;
      data_r <= '0;
      err_r  <= 1'b0;
      eidx_r <= '0;
      cnt    <= '0;
`ifdef OV7670_CFG_READBACK_EN
      arv    <= 1'b0;
`endif
    end else begin
      state  <= st_n;
      idx    <= idx_n;
      awv    <= awv_n;
      wv     <= wv_n;
      addr_r <= addr_n;
      data_r <= data_n;
      err_r  <= err_n;
      eidx_r <= eidx_n;
      cnt    <= cnt_n;
`ifdef OV7670_CFG_READBACK_EN
      arv    <= arv_n;
`endif
    end
  end

endmodule

// File: tb/tb_ov7670_axil_cfg_seq.sv
// Bench for ov7670_axil_cfg_seq: randomized AXI-Lite slave vs reference model.
// Readback cases run when OV7670_CFG_READBACK_EN is defined.
module tb_ov7670_axil_cfg_seq;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef OV7670_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic tb_ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic start = 1'b0;
  logic [N*DW-1:0] cfg_data = '0;
  logic busy, done, error;
  logic [1:0] err_index;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_rready;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_awready = 0, m_axi_wready = 0;
  logic m_axi_bvalid = 0, m_axi_arready = 0;
  logic m_axi_rvalid = 0;
  logic [1:0] m_axi_bresp = 0, m_axi_rresp = 0;
  logic [DW-1:0] m_axi_rdata = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  ov7670_axil_cfg_seq dut (
    .ACLK(tb_ACLK), .ARESET(ARESET),
    .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error),
    .err_index(err_index),
    .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // slave configuration
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int bad_b, bad_r;
  bit no_b;
  logic [DW-1:0] cfg_w [N];

  // slave state
  int aw_c, w_c, b_c, ar_c, r_c;
  int aw_cd, w_cd, b_cd, ar_cd, r_cd;
  bit aw_f, w_f, b_f, ar_f, r_f;
  int aw_hi, w_hi, br_hi;
  bit awp, wp;
  logic [31:0] prev_aw, prev_w;
  logic [31:0] la, ld, lra;
  logic [31:0] mem [16];
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];

  task automatic step();
    @(negedge tb_ACLK);
    #1;
  endtask

  task automatic slv_clear();
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    aw_cd = aw_dly; w_cd = w_dly; b_cd = b_dly;
    ar_cd = ar_dly; r_cd = r_dly;
    aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
    aw_hi = 0; w_hi = 0; br_hi = 0;
    awp = 0; wp = 0;
    aw_q.delete();
    w_q.delete();
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 0; m_axi_arready = 0;
    m_axi_rvalid = 0; m_axi_rdata = 0;
    m_axi_bresp = 0; m_axi_rresp = 0;
  endtask

  // AXI-Lite slave: decides readies/valids at each falling edge
  initial forever begin
    @(negedge tb_ACLK);
    if (!ARESET) begin
      if (awp && m_axi_awvalid)
        check("aw_stable", 64'(m_axi_awaddr), 64'(prev_aw));
      if (wp && m_axi_wvalid)
        check("w_stable", 64'(m_axi_wdata), 64'(prev_w));
      if (aw_f) begin
        m_axi_awready = 0; aw_f = 0; aw_cd = aw_dly;
      end else if (m_axi_awvalid && !m_axi_awready) begin
        if (aw_cd == 0) m_axi_awready = 1;
        else aw_cd--;
      end
      if (w_f) begin
        m_axi_wready = 0; w_f = 0; w_cd = w_dly;
      end else if (m_axi_wvalid && !m_axi_wready) begin
        if (w_cd == 0) m_axi_wready = 1;
        else w_cd--;
      end
      if (b_f) begin
        m_axi_bvalid = 0; b_f = 0; b_c++; b_cd = b_dly;
      end else if (!m_axi_bvalid && !no_b &&
                   aw_c > b_c && w_c > b_c) begin
        if (b_cd == 0) begin
          m_axi_bvalid = 1;
          m_axi_bresp = (b_c == bad_b) ? 2'b10 : 2'b00;
          mem[la[5:2]] = ld;
        end else b_cd--;
      end
      if (ar_f) begin
        m_axi_arready = 0; ar_f = 0; ar_cd = ar_dly;
      end else if (m_axi_arvalid && !m_axi_arready) begin
        if (ar_cd == 0) m_axi_arready = 1;
        else ar_cd--;
      end
      if (r_f) begin
        m_axi_rvalid = 0; r_f = 0; r_c++; r_cd = r_dly;
      end else if (!m_axi_rvalid && ar_c > r_c) begin
        if (r_cd == 0) begin
          m_axi_rvalid = 1;
          m_axi_rresp = 2'b00;
          m_axi_rdata = (r_c == bad_r) ? '0 : mem[lra[5:2]];
        end else r_cd--;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        aw_f = 1; aw_c++; la = m_axi_awaddr;
        aw_q.push_back(la);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_f = 1; w_c++; ld = m_axi_wdata;
        w_q.push_back(ld);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_f = 1; ar_c++; lra = m_axi_araddr;
      end
      b_f = m_axi_bvalid && m_axi_bready;
      r_f = m_axi_rvalid && m_axi_rready;
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid) w_hi++;
      if (m_axi_bready) br_hi++;
      awp = m_axi_awvalid && !aw_f;
      wp = m_axi_wvalid && !w_f;
      prev_aw = m_axi_awaddr;
      prev_w = m_axi_wdata;
    end
  end

  // reference: first faulty word ends the sequence
  task automatic model(output int last, output bit err,
                       output int eidx);
    last = N - 1; err = 0; eidx = 0;
    for (int i = 0; i < N; i++) begin
      if (no_b || i == bad_b || (RB && i == bad_r)) begin
        last = i; err = 1; eidx = i;
        break;
      end
    end
  endtask

  task automatic load_cfg();
    for (int i = 0; i < N; i++)
      cfg_data[i*DW +: DW] = cfg_w[i];
  endtask

  task automatic set_dly(input int a, input int w,
                         input int b, input int r);
    aw_dly = a; w_dly = w; b_dly = b;
    ar_dly = r; r_dly = r;
  endtask

  task automatic run_seq(input string nm);
    int last, eidx, cyc, nd, nw;
    bit err;
    model(last, err, eidx);
    nw = last + 1;
    load_cfg();
    slv_clear();
    start = 1; step(); start = 0;
    check({nm, ":busy"}, 64'(busy), 64'd1);
    check({nm, ":err_clr"}, 64'(error), 64'd0);
    start = 1; step(); start = 0;
    cyc = 0;
    while (!done && cyc < 1000) begin
      step(); cyc++;
    end
    check({nm, ":done"}, 64'(done), 64'd1);
    check({nm, ":busy@done"}, 64'(busy), 64'd0);
    start = 1; step(); start = 0;
    check({nm, ":start@done"}, 64'(busy), 64'd0);
    nd = 0;
    repeat (3) begin
      step(); nd += int'(done);
    end
    check({nm, ":extra_done"}, 64'(nd), 64'd0);
    check({nm, ":error"}, 64'(error), 64'(err));
    if (err)
      check({nm, ":err_idx"}, 64'(err_index), 64'(eidx));
    check({nm, ":n_aw"}, 64'(aw_q.size()), 64'(nw));
    check({nm, ":n_w"}, 64'(w_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < aw_q.size(); i++)
      check({nm, ":awaddr"}, 64'(aw_q[i]), 64'(4 * i));
    for (int i = 0; i < nw && i < w_q.size(); i++)
      check({nm, ":wdata"}, 64'(w_q[i]), 64'(cfg_w[i]));
    check({nm, ":aw_hi"}, 64'(aw_hi), 64'(nw * (aw_dly + 1)));
    check({nm, ":w_hi"}, 64'(w_hi), 64'(nw * (w_dly + 1)));
    check({nm, ":b_hi"}, 64'(br_hi),
          no_b ? 64'd256 : 64'(nw * (b_dly + 1)));
  endtask

  task automatic spec_cfg();
    cfg_w[0] = 32'hbeef0011;
    cfg_w[1] = 32'hdead0011;
    cfg_w[2] = 32'habcd0001;
    cfg_w[3] = 32'h0101FFFF;
    bad_b = -1; bad_r = -1; no_b = 0;
    set_dly(0, 0, 0, 0);
  endtask

  initial begin
    int cyc, k;
    spec_cfg();
    slv_clear();
    repeat (3) step();
    check("rst_ctl", 64'({busy, done, error, err_index}), 64'd0);
    check("rst_axi", 64'({m_axi_awvalid, m_axi_wvalid,
          m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    check("rst_addr", 64'(m_axi_awaddr), 64'd0);
    check("wstrb", 64'(m_axi_wstrb), 64'hF);
    ARESET = 0;
    step();

    run_seq("okay");
    spec_cfg(); bad_b = 2;
    run_seq("bresp");
    spec_cfg(); set_dly(2, 0, 0, 0);
    run_seq("aw_delay");
    check("aw_delay:n_b", 64'(b_c), 64'(N));
    if (RB) begin
      spec_cfg(); bad_r = 1;
      run_seq("rd_bad");
    end
    spec_cfg(); no_b = 1;
    run_seq("timeout");

    spec_cfg(); b_dly = 20;
    load_cfg();
    slv_clear();
    start = 1; step(); start = 0;
    cyc = 0;
    while (!(m_axi_bready && m_axi_awaddr == 32'h4) &&
           cyc < 200) begin
      step(); cyc++;
    end
    check("rst_reach", 64'(m_axi_bready), 64'd1);
    ARESET = 1;
    #1;
    check("arst_ctl", 64'({busy, done, error, err_index}), 64'd0);
    check("arst_axi", 64'({m_axi_awvalid, m_axi_wvalid,
          m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    check("arst_addr", 64'(m_axi_awaddr), 64'd0);
    step();
    ARESET = 0;
    step();
    spec_cfg();
    run_seq("after_rst");

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < N; i++)
        cfg_w[i] = $urandom() | 32'h1;
      set_dly($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      bad_b = -1; bad_r = -1; no_b = 0;
      k = $urandom_range(0, 3);
      if (k == 0) bad_b = $urandom_range(0, N - 1);
      else if (k == 1 && RB) bad_r = $urandom_range(0, N - 1);
      run_seq("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
